// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_pkg
//  Brief    : Shared types, defaults and helpers for the decode instruction
//             buffer slice.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 8;
    localparam int LVL_W     = $clog2(DEF_DEPTH + 1);

    typedef logic [DEF_WIDTH-1:0] instr_t;

    // Wrapping pointer increment; explicit compare so any depth works.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_inst_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_inst_buffer_if
//  Brief    : Fetch/decode handshake bundle plus flush and buffer status.
//  Revision : 1.0 - initial release
// ============================================================================
interface decode_inst_buffer_if #(
    parameter int WIDTH = decode_pkg::DEF_WIDTH,
    parameter int LVL_W = decode_pkg::LVL_W
);
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [LVL_W-1:0] level;
    logic             almost_full;

    // Fetch, decoder and hazard unit collectively
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level, almost_full
    );

    // The buffer itself
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level, almost_full
    );
endinterface
`default_nettype wire

// File: rtl/decode_buf_mem.sv
`default_nettype none
// ============================================================================
//  Module   : decode_buf_mem
//  Brief    : DEPTH x WIDTH register array, synchronous write, async read.
//             Storage is not reset; validity is tracked by the owner.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_buf_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  wire logic             clk,
    input  wire logic             we,
    input  wire logic [AW-1:0]    waddr,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic [AW-1:0]    raddr,
    output logic      [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: one entry per enabled edge
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/decode_inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : decode_inst_buffer
//  Brief    : Elastic instruction buffer between fetch and decode with flush,
//             optional empty-buffer bypass, level and almost-full status.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_inst_buffer
    import decode_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 6,
    parameter int BYPASS    = 0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    decode_inst_buffer_if.slave   bus
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_BITS = $clog2(DEPTH + 1);

    localparam logic [LVL_BITS-1:0] C_DEPTH     = LVL_BITS'(DEPTH);
    localparam logic [LVL_BITS-1:0] C_AF_THRESH = LVL_BITS'(AF_THRESH);
    localparam logic [LVL_BITS-1:0] C_ONE       = LVL_BITS'(1);
    localparam logic                C_BYPASS_EN = (BYPASS != 0);

    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [LVL_BITS-1:0] r_level;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_store;
    logic             w_unload;
    logic             w_we;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty = (r_level == '0);

    // in_ready looks only at registered level and flush, never at out_ready,
    // so a full buffer stays closed even when the decoder pops this cycle.
    assign bus.in_ready  = (r_level < C_DEPTH) && !bus.flush;
    assign bus.out_valid = (!w_empty || (C_BYPASS_EN && bus.in_valid)) && !bus.flush;

    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

    // A pop from an empty buffer can only be the bypassed word: it goes
    // straight through and touches neither storage nor pointers.
    assign w_bypass = w_empty && w_push && w_pop;
    assign w_store  = w_push && !w_bypass;
    assign w_unload = w_pop && !w_bypass;
    assign w_we     = w_store && reset;

    // Bypass only ever serves an empty buffer, which keeps ordering intact.
    assign bus.out_data    = (C_BYPASS_EN && w_empty) ? bus.in_data : w_rdata;
    assign bus.level       = r_level;
    assign bus.almost_full = (r_level >= C_AF_THRESH);

    decode_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (bus.in_data),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // Pointer and level bookkeeping; reset beats flush, flush beats traffic
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else if (bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), 32'(DEPTH)));
            end
            if (w_unload) begin
                r_rd_ptr <= PTR_W'(ptr_inc(32'(r_rd_ptr), 32'(DEPTH)));
            end
            if (w_store && !w_unload) begin
                r_level <= r_level + C_ONE;
            end else if (!w_store && w_unload) begin
                r_level <= r_level - C_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_inst_buffer
//  Brief    : Self-checking bench: three buffer configurations (depth 8,
//             depth 5, depth 8 with bypass) against a list-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_inst_buffer;
    import decode_pkg::*;

    logic   clk;
    logic   reset;
    logic   s_flush [3];
    logic   s_valid [3];
    logic   s_ready [3];
    instr_t s_data  [3];

    logic        d_in_ready  [3];
    logic        d_out_valid [3];
    logic        d_af        [3];
    instr_t      d_out_data  [3];
    int unsigned d_level     [3];

    int total = 0;
    int bad   = 0;
    bit started = 0;

    // Model: per instance an ordered list, element 0 is the oldest word
    instr_t mlist [3][8];
    int     mcnt  [3];

    function automatic int depth_of(input int k);
        return (k == 1) ? 5 : 8;
    endfunction
    function automatic int af_of(input int k);
        return (k == 1) ? 3 : 6;
    endfunction
    function automatic bit byp_of(input int k);
        return (k == 2);
    endfunction

    decode_inst_buffer_if #(.WIDTH(32), .LVL_W(4)) if0 ();
    decode_inst_buffer_if #(.WIDTH(32), .LVL_W(3)) if1 ();
    decode_inst_buffer_if #(.WIDTH(32), .LVL_W(4)) if2 ();

    decode_inst_buffer #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6), .BYPASS(0))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    decode_inst_buffer #(.WIDTH(32), .DEPTH(5), .AF_THRESH(3), .BYPASS(0))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    decode_inst_buffer #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6), .BYPASS(1))
        u2 (.clk(clk), .reset(reset), .bus(if2));

    assign if0.flush = s_flush[0]; assign if0.in_valid = s_valid[0];
    assign if0.in_data = s_data[0]; assign if0.out_ready = s_ready[0];
    assign if1.flush = s_flush[1]; assign if1.in_valid = s_valid[1];
    assign if1.in_data = s_data[1]; assign if1.out_ready = s_ready[1];
    assign if2.flush = s_flush[2]; assign if2.in_valid = s_valid[2];
    assign if2.in_data = s_data[2]; assign if2.out_ready = s_ready[2];

    assign d_in_ready[0] = if0.in_ready;  assign d_out_valid[0] = if0.out_valid;
    assign d_af[0] = if0.almost_full;     assign d_out_data[0] = if0.out_data;
    assign d_level[0] = 32'(if0.level);
    assign d_in_ready[1] = if1.in_ready;  assign d_out_valid[1] = if1.out_valid;
    assign d_af[1] = if1.almost_full;     assign d_out_data[1] = if1.out_data;
    assign d_level[1] = 32'(if1.level);
    assign d_in_ready[2] = if2.in_ready;  assign d_out_valid[2] = if2.out_valid;
    assign d_af[2] = if2.almost_full;     assign d_out_data[2] = if2.out_data;
    assign d_level[2] = 32'(if2.level);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update at each edge from the inputs present before the edge
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit rdy, ov, push, pop;
            if (!reset || s_flush[k]) begin
                mcnt[k] = 0;
            end else begin
                rdy  = (mcnt[k] < depth_of(k));
                ov   = (mcnt[k] != 0) || (byp_of(k) && s_valid[k]);
                push = s_valid[k] && rdy;
                pop  = ov && s_ready[k];
                if (!(mcnt[k] == 0 && push && pop)) begin
                    if (pop) begin
                        for (int j = 0; j < 7; j++) mlist[k][j] = mlist[k][j+1];
                        mcnt[k]--;
                    end
                    if (push) begin
                        mlist[k][mcnt[k]] = s_data[k];
                        mcnt[k]++;
                    end
                end
            end
        end
        if (!reset) started = 1'b1;
    end

    // Level must stay within the configured depth
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            assert (d_level[k] <= 32'(depth_of(k)))
                else $error("FAIL level_bound[%0d]: got %0d", k, d_level[k]);
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                bit e_rdy, e_ov;
                instr_t e_data;
                e_rdy  = (mcnt[k] < depth_of(k)) && !s_flush[k];
                e_ov   = ((mcnt[k] != 0) || (byp_of(k) && s_valid[k])) && !s_flush[k];
                e_data = (mcnt[k] != 0) ? mlist[k][0] : s_data[k];
                chk($sformatf("in_ready[%0d]", k), 32'(d_in_ready[k]), 32'(e_rdy));
                chk($sformatf("out_valid[%0d]", k), 32'(d_out_valid[k]), 32'(e_ov));
                chk($sformatf("level[%0d]", k), d_level[k], 32'(mcnt[k]));
                chk($sformatf("almost_full[%0d]", k), 32'(d_af[k]), 32'(mcnt[k] >= af_of(k)));
                if (e_ov) chk($sformatf("out_data[%0d]", k), d_out_data[k], e_data);
            end
        end
    end

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_flush[k] = 0; s_valid[k] = 0; s_ready[k] = 0; s_data[k] = '0;
        end

        // Reset held two cycles, fetch already presenting on the second
        tick();
        s_valid[0] = 1; s_data[0] = 32'hE3A0_0001;
        #2;
        chk("rst_in_ready", 32'(d_in_ready[0]), 32'd1);
        chk("rst_out_valid", 32'(d_out_valid[0]), 32'd0);
        tick();
        chk("rst_level", d_level[0], 32'd0);
        chk("rst_almost_full", 32'(d_af[0]), 32'd0);
        reset = 1'b1;
        tick();
        s_valid[0] = 0;
        #2;
        chk("first_valid", 32'(d_out_valid[0]), 32'd1);
        chk("first_data", d_out_data[0], 32'hE3A0_0001);
        s_ready[0] = 1;
        tick();
        s_ready[0] = 0;

        // Fill depth-8 buffer to full, then try a ninth push
        for (int i = 1; i <= 8; i++) begin
            s_valid[0] = 1; s_data[0] = 32'(i);
            tick();
            chk("fill_level", d_level[0], 32'(i));
            chk("fill_af", 32'(d_af[0]), (i >= 6) ? 32'd1 : 32'd0);
        end
        s_data[0] = 32'h9;
        #2;
        chk("full_in_ready", 32'(d_in_ready[0]), 32'd0);
        tick();
        s_valid[0] = 0;
        chk("full_level", d_level[0], 32'd8);
        s_ready[0] = 1;
        for (int i = 1; i <= 8; i++) begin
            #2;
            chk("drain_data", d_out_data[0], 32'(i));
            tick();
        end
        s_ready[0] = 0;
        chk("drain_level", d_level[0], 32'd0);

        // Wrap on depth 5: level held at 2 over 12 push/pop pairs
        s_valid[1] = 1; s_data[1] = 32'hA0; tick();
        s_data[1] = 32'hA1; tick();
        s_ready[1] = 1;
        for (int i = 0; i < 12; i++) begin
            s_data[1] = 32'hA2 + 32'(i);
            #2;
            chk("wrap_data", d_out_data[1], 32'hA0 + 32'(i));
            tick();
            chk("wrap_level", d_level[1], 32'd2);
        end
        s_valid[1] = 0;
        tick(); tick();
        s_ready[1] = 0;

        // Simultaneous push and pop at level 3
        s_valid[0] = 1;
        for (int i = 0; i < 3; i++) begin
            s_data[0] = 32'hB0 + 32'(i); tick();
        end
        s_data[0] = 32'hB3; s_ready[0] = 1;
        #2;
        chk("pp_oldest", d_out_data[0], 32'hB0);
        tick();
        s_valid[0] = 0;
        chk("pp_level", d_level[0], 32'd3);
        for (int i = 1; i <= 3; i++) begin
            #2;
            chk("pp_order", d_out_data[0], 32'hB0 + 32'(i));
            tick();
        end
        s_ready[0] = 0;

        // Flush at level 4 together with a push and a pop
        s_valid[0] = 1;
        for (int i = 0; i < 4; i++) begin
            s_data[0] = 32'hC0 + 32'(i); tick();
        end
        s_data[0] = 32'hDEAD; s_ready[0] = 1; s_flush[0] = 1;
        #2;
        chk("flush_in_ready", 32'(d_in_ready[0]), 32'd0);
        chk("flush_out_valid", 32'(d_out_valid[0]), 32'd0);
        tick();
        s_flush[0] = 0; s_valid[0] = 0;
        chk("flush_level", d_level[0], 32'd0);
        chk("post_flush_valid", 32'(d_out_valid[0]), 32'd0);
        tick();
        s_ready[0] = 0;

        // Bypass: same-cycle delivery when consumed, stored when not
        s_valid[2] = 1; s_data[2] = 32'h1234; s_ready[2] = 1;
        #2;
        chk("byp_valid", 32'(d_out_valid[2]), 32'd1);
        chk("byp_data", d_out_data[2], 32'h1234);
        tick();
        chk("byp_level", d_level[2], 32'd0);
        s_ready[2] = 0;
        tick();
        s_valid[2] = 0;
        chk("byp_stall_level", d_level[2], 32'd1);
        chk("byp_stall_data", d_out_data[2], 32'h1234);
        s_ready[2] = 1; tick(); s_ready[2] = 0;

        // Reset mid-stream discards contents
        s_valid[0] = 1; s_data[0] = 32'h55; tick(); tick();
        s_valid[0] = 0; reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_level", d_level[0], 32'd0);
        chk("midrst_valid", 32'(d_out_valid[0]), 32'd0);

        // Randomized traffic with alternating fill/drain bias
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < 3; k++) begin
                s_flush[k] = ($urandom_range(0, 31) == 0);
                s_valid[k] = ($urandom_range(0, 3) != 0);
                s_data[k]  = $urandom;
                s_ready[k] = (((n / 200) % 2) == 0) ? ($urandom_range(0, 3) == 0)
                                                    : ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
